freq_meas: RTL

- Frequency meter: the receive-side inverse of the team's phase-accumulator frequency generator.
- Counts rising edges of an asynchronous input `sig_in` over a fixed gate window of 2^(DataWidth+1) `clk_in` cycles.
- Reports a code in the generator's `freq_sel` encoding, so a generator/meter pair round-trips exactly.
- Used for loopback self-test and for measuring external clocks relative to `clk_in`.

---
 rtl/freq_meas.sv | 106 ++++++++++
 1 files changed

// File: rtl/freq_meas.sv
// Frequency meter: counts rising edges of an asynchronous input over a gate window of
// 2^(DataWidth+1) clk_in cycles and reports them in the generator's freq_sel encoding.
module freq_meas #(
  parameter int DataWidth = 8
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sig_in,
  output logic [DataWidth-1:0] freq_est,
  output logic                 no_sig,
  output logic                 valid
);

  localparam int CntW = DataWidth + 1;
  localparam logic [CntW-1:0] WinLast = '1;
  localparam logic [CntW-1:0] CntMax  = CntW'(1) << DataWidth;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  logic [1:0]      state;
  logic [1:0]      settle_cnt;
  logic            s1, s2, s3;
  logic            rise;
  logic [CntW-1:0] win_cnt;
  logic [CntW-1:0] edge_cnt;
  logic [CntW-1:0] edge_nxt;

  // Edge count can legally reach 2^DataWidth but must never wrap past it.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] c, input logic inc);
    if (inc && (c != CntMax)) return c + CntW'(1);
    return c;
  endfunction

  function automatic logic [DataWidth-1:0] map_code(input logic [CntW-1:0] c);
    logic [CntW-1:0] m;
    m = (c == '0) ? '0 : c - CntW'(1);
    return m[DataWidth-1:0];
  endfunction

  assign rise     = s2 & ~s3;
  assign edge_nxt = sat_inc(edge_cnt, rise);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      freq_est   <= '0;
      no_sig     <= 1'b0;
      valid      <= 1'b0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          win_cnt    <= '0;
          edge_cnt   <= '0;
          settle_cnt <= '0;
          if (en) state <= SETTLE;
        end
        SETTLE: begin
          // Three cycles let stale samples drain out of the synchroniser.
          if (!en) begin
            state      <= IDLE;
            settle_cnt <= '0;
          end else if (settle_cnt == 2'd2) begin
            state      <= MEASURE;
            settle_cnt <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
          end else begin
            settle_cnt <= settle_cnt + 2'd1;
          end
        end
        MEASURE: begin
          if (!en) begin
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end else if (win_cnt == WinLast) begin
            // Last window cycle: its own rise is included, next window starts with no gap.
            freq_est <= map_code(edge_nxt);
            no_sig   <= (edge_nxt == '0);
            valid    <= 1'b1;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            win_cnt  <= win_cnt + CntW'(1);
            edge_cnt <= edge_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
